stream_demux1to4: RTL
=====================

STREAM_DEMUX1TO4 -- requirements
Module: stream_demux1to4

Interface
REQ-001 The block SHALL have parameter DWidth, default 32, giving the data beat width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port data_i, input, DWidth, the input beat data.
REQ-005 The block SHALL have port select_i, input, 2, the destination channel, sampled only at packet start.
REQ-006 The block SHALL have port valid_i, input, 1, the input beat valid.
REQ-007 The block SHALL have port last_i, input, 1, the last beat of a packet.
REQ-008 The block SHALL have port ready_o, output, 1, the input beat accept.
REQ-009 The block SHALL have port data_o, output, 4 x DWidth, the per-channel output data.
REQ-010 The block SHALL have port valid_o, output, 4, the per-channel output valid.
REQ-011 The block SHALL have port last_o, output, 4, the per-channel last flag.
REQ-012 The block SHALL have port ready_i, input, 4, the per-channel downstream ready.
REQ-013 The block SHALL have port busy_o, output, 1, high while a multi-beat packet is in progress.
REQ-014 The block SHALL have port route_o, output, 2, the effective destination channel this cycle.

Function
REQ-015 The FSM SHALL have states IDLE and ROUTE, holding a 2-bit route register route_q.
REQ-016 The effective route r SHALL be select_i in IDLE and route_q in ROUTE; route_o = r; select_i is ignored in ROUTE.
REQ-017 ready_o SHALL equal (~valid_o[r] | ready_i[r]), combinational and independent of valid_i.
REQ-018 A beat SHALL be accepted when valid_i & ready_o, and only then.
REQ-019 On accept in IDLE with last_i=0, the FSM SHALL move to ROUTE and load route_q with select_i.
REQ-020 On accept in IDLE with last_i=1 (single-beat packet), the FSM SHALL stay in IDLE.
REQ-021 On accept in ROUTE with last_i=1, the FSM SHALL return to IDLE; with last_i=0 it stays in ROUTE.
REQ-022 Each channel k SHALL hold one output slot (valid_o[k], data_o[k], last_o[k]) registered with 1-cycle latency from accept.
REQ-023 Slot k SHALL load data_i/last_i and set valid_o[k] on an accepted beat routed to k.
REQ-024 Slot k SHALL clear valid_o[k] on valid_o[k] & ready_i[k] with no load; a simultaneous drain and load SHALL replace the slot with no bubble (1 beat/cycle sustained).
REQ-025 While valid_o[k]=1 and ready_i[k]=0, data_o[k] and last_o[k] SHALL remain stable.
REQ-026 Channels SHALL drain independently; a stalled channel SHALL block input only when it is r.
REQ-027 busy_o SHALL be 1 exactly when the FSM is in ROUTE.
REQ-028 With no accept, the FSM and route_q SHALL hold; data_o[k] SHALL hold when not loaded.

Reset
REQ-029 On rst_n low, asynchronously: state=IDLE, route_q=0, valid_o=0, last_o=0, data_o=0, busy_o=0.
REQ-030 Reset mid-packet SHALL discard all slot contents and the partial route; the first accepted beat after release is treated as a packet start.

Structure
REQ-031 A shared package SHALL hold the FSM state enum typedef (IDLE, ROUTE), the constant NUM_CH=4 and the select width constant 2.
REQ-032 One sub-module, stream_slot (one-entry valid/ready register, DWidth+1 bits), SHALL be instantiated four times.

Verification
REQ-033 Single beat: select_i=2, data_i=32'hA5A5_0001, last_i=1, all ready_i=1 -> next cycle valid_o=4'b0100, data_o[2]=32'hA5A5_0001, last_o[2]=1; busy_o stays 0.
REQ-034 Packet lock: 3 beats 0x10,0x11,0x12 with select_i=1,3,0 and last only on beat 3 -> all beats exit channel 1; busy_o=1 after beat 1 until beat 3 is accepted.
REQ-035 Backpressure: ready_i[0]=0, two beats to channel 0 -> first held in slot, ready_o=0 on second; raise ready_i[0] -> second accepted the same cycle, no beat lost or duplicated.
REQ-036 Independence: channel 3 stalled and full, beats to channel 1 -> ready_o=1 and channel 1 sustains 1 beat/cycle.
REQ-037 Reset mid-packet: assert rst_n=0 after beat 2 of a 4-beat packet -> valid_o=0, busy_o=0 immediately; after release, select_i=2 routes the next beat to channel 2.
REQ-038 Random traffic with random ready_i versus a scoreboard model -> per-channel order preserved and every beat delivered exactly once.

Source files
------------

// File: rtl/stream_demux1to4_pkg.sv
// Shared definitions for the 1-to-4 packet stream demultiplexer:
// channel count, select width and the packet-tracking FSM states.
package stream_demux1to4_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        ROUTE = 1'b1
    } state_e;

endpackage

// File: rtl/stream_slot.sv
// One-entry valid/ready output register. A load always wins and replaces the
// entry, so a simultaneous drain and load sustains one beat per cycle.
module stream_slot #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (load_i) begin
            r_valid <= 1'b1;
            r_data  <= data_i;
        end else if (r_valid && ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;

endmodule

// File: rtl/stream_demux1to4.sv
// Packet-aware 1-to-4 stream demultiplexer: the channel is chosen by select_i
// on the first beat of a packet and locked until the last beat is accepted.
module stream_demux1to4
    import stream_demux1to4_pkg::*;
#(
    parameter int DWidth = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DWidth-1:0]              data_i,
    input  logic [SEL_W-1:0]               select_i,
    input  logic                           valid_i,
    input  logic                           last_i,
    output logic                           ready_o,
    output logic [NUM_CH-1:0][DWidth-1:0]  data_o,
    output logic [NUM_CH-1:0]              valid_o,
    output logic [NUM_CH-1:0]              last_o,
    input  logic [NUM_CH-1:0]              ready_i,
    output logic                           busy_o,
    output logic [SEL_W-1:0]               route_o
);

    state_e            r_state;
    state_e            w_state_next;
    logic [SEL_W-1:0]  r_route_q;
    logic [SEL_W-1:0]  w_route;
    logic              w_accept;
    logic              w_load_route;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_route_q <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load_route) begin
                r_route_q <= select_i;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load_route = 1'b0;
        if (w_accept) begin
            case (r_state)
                IDLE: begin
                    if (!last_i) begin
                        w_state_next = ROUTE;
                        w_load_route = 1'b1;
                    end
                end
                ROUTE: begin
                    if (last_i) begin
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Input readiness depends only on the slot of the effective route, never on valid_i.
    always_comb begin
        w_route  = (r_state == ROUTE) ? r_route_q : select_i;
        route_o  = w_route;
        ready_o  = ~valid_o[w_route] | ready_i[w_route];
        w_accept = valid_i & ready_o;
        busy_o   = (r_state == ROUTE);
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic              w_load;
            logic [DWidth:0]   w_slot_q;

            assign w_load = w_accept && (w_route == SEL_W'(gi));

            stream_slot #(
                .W (DWidth + 1)
            ) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .load_i  (w_load),
                .data_i  ({last_i, data_i}),
                .ready_i (ready_i[gi]),
                .valid_o (valid_o[gi]),
                .data_o  (w_slot_q)
            );

            assign data_o[gi] = w_slot_q[DWidth-1:0];
            assign last_o[gi] = w_slot_q[DWidth];
        end
    endgenerate

endmodule
